cas_player: RTL and testbench

CAS_PLAYER -- requirements
Module: cas_player

---
 rtl/cas_player.sv | 128 ++++++++++++
 tb/tb_cas_player.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_player.sv
// cas_player: plays a byte-oriented tape image out of a dual-port RAM as a
// Kansas-City style FSK bit stream (one full square wave per bit, LSB first).
// A 0 bit uses HALF0 clk cycles per half-period and a 1 bit uses HALF1.
// Dropping the motor freezes the player in place; rewind returns to byte 0.
module cas_player #(
  parameter int HALF0 = 23863,
  parameter int HALF1 = 11932
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor,
  input  logic        rewind,
  input  logic [15:0] tape_len,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        cas_out,
  output logic        playing,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [14:0] HALF0_M1 = 15'(HALF0 - 1);
  localparam logic [14:0] HALF1_M1 = 15'(HALF1 - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pos;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bitcnt;
  logic [14:0] r_cnt;
  logic        w_cnt_zero;
  logic        w_more;
  logic        w_last_bit;

  // Half-period reload value (minus one) for the bit about to be sent.
  function automatic logic [14:0] half_m1(input logic b);
    return b ? HALF1_M1 : HALF0_M1;
  endfunction

  assign w_cnt_zero = (r_cnt == 15'd0);
  assign w_more     = (r_pos < tape_len);
  assign w_last_bit = (r_bitcnt == 3'd7);

  // State register; reset wins over everything, rewind is folded into w_next.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; motor=0 holds every state, DONE only leaves on rewind.
  always_comb begin
    w_next = r_state;
    if (rewind) begin
      w_next = S_IDLE;
    end else if (motor) begin
      case (r_state)
        S_IDLE:  w_next = w_more ? S_FETCH : S_DONE;
        S_FETCH: w_next = S_WAIT;
        S_WAIT:  w_next = S_HIGH;
        S_HIGH:  if (w_cnt_zero) w_next = S_LOW;
        S_LOW: begin
          if (w_cnt_zero) begin
            if (!w_last_bit) w_next = S_HIGH;
            else             w_next = w_more ? S_FETCH : S_DONE;
          end
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Byte position, shift register, bit counter and half-period counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pos    <= 16'd0;
      r_shreg  <= 8'd0;
      r_bitcnt <= 3'd0;
      r_cnt    <= 15'd0;
    end else if (rewind) begin
      r_pos <= 16'd0;
    end else if (motor) begin
      case (r_state)
        S_WAIT: begin
          r_shreg  <= rd_data;
          r_bitcnt <= 3'd0;
          r_cnt    <= half_m1(rd_data[0]);
          r_pos    <= r_pos + 16'd1;
        end
        S_HIGH: begin
          if (w_cnt_zero) r_cnt <= half_m1(r_shreg[0]);
          else            r_cnt <= r_cnt - 15'd1;
        end
        S_LOW: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 15'd1;
          end else if (!w_last_bit) begin
            // Next bit comes from shreg[1] since the shift lands this edge.
            r_shreg  <= {1'b0, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            r_cnt    <= half_m1(r_shreg[1]);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state and gated by the motor so a freeze is silent.
  always_comb begin
    rd_addr = r_pos;
    rd_req  = motor && (r_state == S_FETCH);
    cas_out = motor && (r_state == S_HIGH);
    playing = motor && ((r_state == S_FETCH) || (r_state == S_WAIT) ||
                        (r_state == S_HIGH)  || (r_state == S_LOW));
    done    = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: directed bench for cas_player with HALF0=8, HALF1=4.
// A registered dpram model answers reads one cycle after rd_req.
module tb_cas_player;

  logic        clk;
  logic        reset;
  logic        motor;
  logic        rewind;
  logic [15:0] tape_len;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        cas_out;
  logic        playing;
  logic        done;

  logic [7:0]  mem [0:3];

  int n_pass;
  int n_total;

  cas_player #(.HALF0(8), .HALF1(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .motor    (motor),
    .rewind   (rewind),
    .tape_len (tape_len),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cas_out  (cas_out),
    .playing  (playing),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image RAM with one cycle read latency.
  always @(posedge clk) begin
    if (rd_req) rd_data <= mem[rd_addr[1:0]];
  end

  typedef struct {
    logic [7:0] data;
    int         exp_span;   // first cas_out high to done, in cycles
    int         exp_high;   // total cycles with cas_out=1
    int         exp_first;  // length of the first high run
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_rewind();
    motor  = 1'b0;
    rewind = 1'b1;
    step();
    rewind = 1'b0;
  endtask

  // Play from the current point with motor=1 and record waveform events.
  task automatic run_tape(input int budget, output int n_rd, output int t_rd2,
                          output int a_rd2, output int t_fh, output int first_run,
                          output int n_high, output int t_done);
    logic in_first;
    n_rd = 0; t_rd2 = -1; a_rd2 = -1; t_fh = -1; first_run = 0;
    n_high = 0; t_done = -1; in_first = 1'b0;
    motor = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (rd_req) begin
        n_rd++;
        if (n_rd == 2) begin
          t_rd2 = k;
          a_rd2 = int'(rd_addr);
        end
      end
      if (cas_out) begin
        n_high++;
        if (t_fh < 0) begin
          t_fh     = k;
          in_first = 1'b1;
        end
        if (in_first) first_run++;
      end else if (t_fh >= 0) begin
        in_first = 1'b0;
      end
      if (done) begin
        t_done = k;
        break;
      end
    end
  endtask

  initial begin
    int n_rd, t_rd2, a_rd2, t_fh, first_run, n_high, t_done;
    int hi, lo, rdseen, guard;

    n_pass  = 0;
    n_total = 0;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

    // One-byte tapes: ones last 8 cycles, zeros 16 cycles, half of each high.
    vecs[0] = '{data: 8'h01, exp_span: 120, exp_high: 60, exp_first: 4};
    vecs[1] = '{data: 8'hFF, exp_span: 64,  exp_high: 32, exp_first: 4};
    vecs[2] = '{data: 8'h00, exp_span: 128, exp_high: 64, exp_first: 8};
    vecs[3] = '{data: 8'hA5, exp_span: 96,  exp_high: 48, exp_first: 4};
    vecs[4] = '{data: 8'h80, exp_span: 120, exp_high: 60, exp_first: 8};

    // Reset overrides motor and rewind.
    reset = 1'b0; motor = 1'b1; rewind = 1'b1; tape_len = 16'd1;
    step();
    step();
    chk("reset_rd_req",  int'(rd_req),  0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_cas_out", int'(cas_out), 0);
    chk("reset_playing", int'(playing), 0);
    chk("reset_done",    int'(done),    0);

    // Empty tape: straight to DONE, no reads; rewind clears done for one cycle.
    reset = 1'b1; rewind = 1'b0; motor = 1'b1; tape_len = 16'd0;
    rdseen = 0;
    step();
    rdseen += int'(rd_req);
    chk("empty_done_1cyc", int'(done), 1);
    chk("empty_cas_out", int'(cas_out), 0);
    step();
    rdseen += int'(rd_req);
    chk("empty_done_sticky", int'(done), 1);
    rewind = 1'b1;
    step();
    rdseen += int'(rd_req);
    rewind = 1'b0;
    chk("empty_rewind_clears", int'(done), 0);
    step();
    rdseen += int'(rd_req);
    chk("empty_done_again", int'(done), 1);
    chk("empty_no_reads", rdseen, 0);

    // Table-driven one-byte tapes.
    for (int i = 0; i < 5; i++) begin
      do_rewind();
      tape_len = 16'd1;
      mem[0]   = vecs[i].data;
      run_tape(400, n_rd, t_rd2, a_rd2, t_fh, first_run, n_high, t_done);
      if (t_done < 0) begin
        chk($sformatf("v%0d_timeout", i), 0, 1);
      end else begin
        chk($sformatf("v%0d_reads", i), n_rd, 1);
        chk($sformatf("v%0d_first_high_cycle", i), t_fh, 3);
        chk($sformatf("v%0d_span", i), t_done - t_fh, vecs[i].exp_span);
        chk($sformatf("v%0d_high_cycles", i), n_high, vecs[i].exp_high);
        chk($sformatf("v%0d_first_run", i), first_run, vecs[i].exp_first);
      end
    end

    // Two-byte tape FF,00: second fetch right after the last LOW, 2-cycle gap.
    do_rewind();
    tape_len = 16'd2;
    mem[0] = 8'hFF; mem[1] = 8'h00;
    run_tape(400, n_rd, t_rd2, a_rd2, t_fh, first_run, n_high, t_done);
    chk("two_reads", n_rd, 2);
    chk("two_rd2_cycle", t_rd2, 67);
    chk("two_rd2_addr", a_rd2, 1);
    chk("two_high_cycles", n_high, 96);
    chk("two_done_cycle", t_done, 197);

    // Motor freeze at cnt=5 of the first HIGH of a 0 bit.
    do_rewind();
    tape_len = 16'd1;
    mem[0] = 8'h00;
    motor = 1'b1;
    repeat (5) step();
    motor = 1'b0;
    #1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      hi += int'(cas_out) + int'(rd_req) + int'(playing);
    end
    chk("freeze_silent", hi, 0);
    step();
    motor = 1'b1;
    #1;
    hi = 0;
    lo = 0;
    while (cas_out && hi < 50) begin hi++; step(); end
    while (!cas_out && lo < 50) begin lo++; step(); end
    chk("freeze_resume_high", hi, 6);
    chk("freeze_resume_low", lo, 8);

    // Reset in the middle of a LOW phase.
    guard = 0;
    while (cas_out && guard < 50) begin guard++; step(); end
    step();
    step();
    chk("midlow_is_low", int'(cas_out == 1'b0 && playing == 1'b1), 1);
    reset = 1'b0;
    step();
    chk("midlow_rst_rd_req",  int'(rd_req),  0);
    chk("midlow_rst_rd_addr", int'(rd_addr), 0);
    chk("midlow_rst_cas_out", int'(cas_out), 0);
    chk("midlow_rst_playing", int'(playing), 0);
    chk("midlow_rst_done",    int'(done),    0);
    reset = 1'b1;
    step();
    chk("midlow_restart_rd_req", int'(rd_req), 1);
    chk("midlow_restart_addr", int'(rd_addr), 0);

    // Rewind during byte 1 of a 3-byte tape.
    do_rewind();
    tape_len = 16'd3;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    motor = 1'b1;
    guard = 0;
    rdseen = 0;
    while (guard < 300 && rdseen == 0) begin
      step();
      guard++;
      if (rd_req && rd_addr == 16'd1) rdseen = 1;
    end
    chk("rew_saw_byte1_fetch", rdseen, 1);
    repeat (10) step();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    chk("rew_cas_out", int'(cas_out), 0);
    chk("rew_done", int'(done), 0);
    chk("rew_rd_addr", int'(rd_addr), 0);
    chk("rew_idle_no_req", int'(rd_req), 0);
    step();
    chk("rew_refetch_req", int'(rd_req), 1);
    chk("rew_refetch_addr", int'(rd_addr), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
